// File: rtl/rr_arbiter.sv
// Round-robin / fixed-priority arbiter with registered one-hot grant.
// A grant is held until done or until the holder drops its request.
module rr_arbiter #(
    parameter int unsigned WORD_WIDTH = 4,
    parameter int unsigned MODE       = 0,
    parameter int unsigned IDX_WIDTH  = $clog2(WORD_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WORD_WIDTH-1:0] reqs,
    input  logic                  done,
    output logic [WORD_WIDTH-1:0] grants,
    output logic                  grant_valid,
    output logic [IDX_WIDTH-1:0]  grant_idx
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    localparam logic [WORD_WIDTH-1:0] ONE      = WORD_WIDTH'(1);
    localparam logic [WORD_WIDTH-1:0] LAST_RST = {1'b1, {(WORD_WIDTH-1){1'b0}}};

    logic [0:0]            state_q, state_d;
    logic [WORD_WIDTH-1:0] last_q, last_d;
    logic [WORD_WIDTH-1:0] grants_q, grants_d;
    logic                  valid_q, valid_d;
    logic [IDX_WIDTH-1:0]  idx_q, idx_d;

    logic                  holder_req;
    logic                  release_grant;
    logic [WORD_WIDTH-1:0] cand;
    logic [WORD_WIDTH-1:0] above_last;
    logic [WORD_WIDTH-1:0] masked;
    logic [WORD_WIDTH-1:0] rr_pick;
    logic [WORD_WIDTH-1:0] fp_pick;
    logic [WORD_WIDTH-1:0] winner;
    logic [IDX_WIDTH-1:0]  winner_idx;

    // The holder is excluded from candidates so a release re-arbitrates among the others.
    always_comb begin
        holder_req    = |(reqs & grants_q);
        release_grant = (state_q == BUSY) && (done || !holder_req);
        cand          = (state_q == BUSY) ? (reqs & ~grants_q) : reqs;
    end

    // Bits strictly above the one-hot pointer; empty when the pointer is the MSB.
    always_comb begin
        above_last = ~(last_q | (last_q - ONE));
        masked     = cand & above_last;
        rr_pick    = (|masked) ? (masked & (~masked + ONE)) : (cand & (~cand + ONE));
        fp_pick    = cand & (~cand + ONE);
        winner     = (MODE == 1) ? fp_pick : rr_pick;
    end

    always_comb begin
        winner_idx = '0;
        for (int i = 0; i < WORD_WIDTH; i++) begin
            if (winner[i]) begin
                winner_idx = winner_idx | IDX_WIDTH'(i);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        grants_d = grants_q;
        valid_d  = valid_q;
        idx_d    = idx_q;
        case (state_q)
            IDLE: begin
                if (|cand) begin
                    state_d  = BUSY;
                    last_d   = winner;
                    grants_d = winner;
                    valid_d  = 1'b1;
                    idx_d    = winner_idx;
                end
            end
            BUSY: begin
                if (release_grant) begin
                    if (|cand) begin
                        last_d   = winner;
                        grants_d = winner;
                        valid_d  = 1'b1;
                        idx_d    = winner_idx;
                    end else begin
                        state_d  = IDLE;
                        grants_d = '0;
                        valid_d  = 1'b0;
                        idx_d    = '0;
                    end
                end
            end
            default: begin
                state_d  = IDLE;
                grants_d = '0;
                valid_d  = 1'b0;
                idx_d    = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            last_q   <= LAST_RST;
            grants_q <= '0;
            valid_q  <= 1'b0;
            idx_q    <= '0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            grants_q <= grants_d;
            valid_q  <= valid_d;
            idx_q    <= idx_d;
        end
    end

    assign grants      = grants_q;
    assign grant_valid = valid_q;
    assign grant_idx   = idx_q;

endmodule

// File: tb/tb_rr_arbiter.sv
// Scoreboard bench for rr_arbiter: a round-robin and a fixed-priority instance
// share stimulus; a queue-based model predicts each registered grant.
module tb_rr_arbiter;

    localparam int W  = 5;
    localparam int IW = $clog2(W);

    typedef struct packed {
        logic [W-1:0]  g;
        logic          v;
        logic [IW-1:0] i;
    } exp_t;

    logic          clk;
    logic          rst;
    logic [W-1:0]  reqs;
    logic          done;
    logic [W-1:0]  g_rr, g_fp;
    logic          v_rr, v_fp;
    logic [IW-1:0] i_rr, i_fp;

    int n_checks = 0;
    int n_fail   = 0;

    exp_t q_rr[$];
    exp_t q_fp[$];

    int rr_holder = -1, rr_last = W - 1;
    int fp_holder = -1, fp_last = W - 1;

    rr_arbiter #(.WORD_WIDTH(W), .MODE(0)) dut_rr (
        .clk(clk), .rst(rst), .reqs(reqs), .done(done),
        .grants(g_rr), .grant_valid(v_rr), .grant_idx(i_rr)
    );

    rr_arbiter #(.WORD_WIDTH(W), .MODE(1)) dut_fp (
        .clk(clk), .rst(rst), .reqs(reqs), .done(done),
        .grants(g_fp), .grant_valid(v_fp), .grant_idx(i_fp)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Next requester in circular order after last (round-robin), or lowest index (fixed).
    function automatic int arb(input int mode, input logic [W-1:0] r, input int excl,
                               input int last);
        int idx;
        if (mode == 1) begin
            for (int k = 0; k < W; k++) if (r[k] && k != excl) return k;
        end else begin
            for (int k = 1; k <= W; k++) begin
                idx = (last + k) % W;
                if (r[idx] && idx != excl) return idx;
            end
        end
        return -1;
    endfunction

    task automatic advance(input int mode, input logic [W-1:0] r, input logic d,
                           inout int holder, inout int last);
        int w;
        if (holder < 0) w = arb(mode, r, -1, last);
        else if (d || !r[holder]) w = arb(mode, r, holder, last);
        else w = holder;
        holder = w;
        if (w >= 0) last = w;
    endtask

    function automatic exp_t mk(input int holder);
        exp_t e;
        e.g = (holder >= 0) ? (W'(1) << holder) : '0;
        e.v = (holder >= 0);
        e.i = (holder >= 0) ? IW'(holder) : '0;
        return e;
    endfunction

    task automatic model_reset();
        rr_holder = -1; rr_last = W - 1;
        fp_holder = -1; fp_last = W - 1;
    endtask

    task automatic push_exp();
        q_rr.push_back(mk(rr_holder));
        q_fp.push_back(mk(fp_holder));
    endtask

    task automatic step(input logic [W-1:0] r, input logic d);
        @(negedge clk);
        rst  = 1'b0;
        reqs = r;
        done = d;
        advance(0, r, d, rr_holder, rr_last);
        advance(1, r, d, fp_holder, fp_last);
        push_exp();
    endtask

    task automatic reset_cycles(input int n);
        repeat (n) begin
            @(negedge clk);
            rst  = 1'b1;
            reqs = '0;
            done = 1'b0;
            model_reset();
            push_exp();
        end
    endtask

    task automatic mid_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_rst_rr_grants", 32'(g_rr), 32'd0);
        check("async_rst_rr_valid", 32'(v_rr), 32'd0);
        check("async_rst_fp_grants", 32'(g_fp), 32'd0);
        model_reset();
        push_exp();
    endtask

    task automatic expect_at_edge(input string name, input logic [W-1:0] act_sel_fp,
                                  input logic [W-1:0] exp);
        @(posedge clk);
        #1;
        if (act_sel_fp[0]) check(name, 32'(g_fp), 32'(exp));
        else check(name, 32'(g_rr), 32'(exp));
    endtask

    // Monitor: pops the expected response for every edge and checks structural properties.
    int           waitc[W];
    logic [W-1:0] prev_g = '0;
    logic         new_grant;
    exp_t         e;

    initial begin
        for (int k = 0; k < W; k++) waitc[k] = 0;
        forever begin
            @(posedge clk);
            #1;
            if (q_rr.size() != 0) begin
                e = q_rr.pop_front();
                check("rr_grants", 32'(g_rr), 32'(e.g));
                check("rr_valid", 32'(v_rr), 32'(e.v));
                check("rr_idx", 32'(i_rr), 32'(e.i));
            end
            if (q_fp.size() != 0) begin
                e = q_fp.pop_front();
                check("fp_grants", 32'(g_fp), 32'(e.g));
                check("fp_valid", 32'(v_fp), 32'(e.v));
                check("fp_idx", 32'(i_fp), 32'(e.i));
            end
            check("rr_onehot0", 32'($onehot0(g_rr)), 32'd1);
            check("rr_valid_or", 32'(v_rr), 32'(|g_rr));
            check("rr_idx_match", 32'(g_rr), v_rr ? (32'd1 << i_rr) : 32'd0);
            check("fp_onehot0", 32'($onehot0(g_fp)), 32'd1);
            check("fp_valid_or", 32'(v_fp), 32'(|g_fp));
            check("fp_idx_match", 32'(g_fp), v_fp ? (32'd1 << i_fp) : 32'd0);
            new_grant = v_rr && (g_rr != prev_g);
            for (int k = 0; k < W; k++) begin
                if (rst || !reqs[k] || g_rr[k]) begin
                    waitc[k] = 0;
                end else if (new_grant) begin
                    waitc[k]++;
                    check("rr_starvation", 32'(waitc[k] <= W - 1), 32'd1);
                end
            end
            prev_g = rst ? '0 : g_rr;
        end
    end

    logic [W-1:0] r;

    initial begin
        rst  = 1'b1;
        reqs = '0;
        done = 1'b0;
        reset_cycles(2);
        @(negedge clk);
        check("reset_grants", 32'(g_rr), 32'd0);
        check("reset_valid", 32'(v_rr), 32'd0);
        check("reset_idx", 32'(i_rr), 32'd0);

        // All requesting, done every cycle: strict rotation from bit 0.
        step(5'b01111, 1'b1); expect_at_edge("rot0", 5'd0, 5'b00001);
        step(5'b01111, 1'b1); expect_at_edge("rot1", 5'd0, 5'b00010);
        step(5'b01111, 1'b1); expect_at_edge("rot2", 5'd0, 5'b00100);
        step(5'b01111, 1'b1); expect_at_edge("rot3", 5'd0, 5'b01000);
        step(5'b01111, 1'b1); expect_at_edge("rot4", 5'd0, 5'b00001);

        // Grant held while done is low, then hand-off to bit 3.
        reset_cycles(1);
        for (int k = 0; k < 5; k++) begin
            step(5'b01010, 1'b0); expect_at_edge("hold_1010", 5'd0, 5'b00010);
        end
        step(5'b01010, 1'b1); expect_at_edge("handoff_1010", 5'd0, 5'b01000);
        check("handoff_idx", 32'(i_rr), 32'd3);

        // Fixed priority excludes the holder on release.
        reset_cycles(1);
        step(5'b01110, 1'b1); expect_at_edge("fp_a", 5'd1, 5'b00010);
        step(5'b01110, 1'b1); expect_at_edge("fp_b", 5'd1, 5'b00100);
        step(5'b01110, 1'b1); expect_at_edge("fp_c", 5'd1, 5'b00010);
        step(5'b01000, 1'b1); expect_at_edge("fp_d", 5'd1, 5'b01000);

        // Abort with nothing pending returns to idle.
        reset_cycles(1);
        step(5'b00100, 1'b0); expect_at_edge("abort_a", 5'd0, 5'b00100);
        step(5'b00100, 1'b0); expect_at_edge("abort_b", 5'd0, 5'b00100);
        step(5'b00000, 1'b0); expect_at_edge("abort_c", 5'd0, 5'b00000);
        check("abort_valid", 32'(v_rr), 32'd0);
        step(5'b00000, 1'b1); expect_at_edge("idle_done", 5'd0, 5'b00000);

        // Asynchronous reset mid-grant, then first grant uses the reset pointer.
        reset_cycles(1);
        step(5'b00010, 1'b0); expect_at_edge("pre_rst", 5'd0, 5'b00010);
        mid_reset();
        step(5'b00110, 1'b0); expect_at_edge("post_rst", 5'd0, 5'b00010);

        // Randomized traffic with sticky requests so grants are held for a while.
        reset_cycles(1);
        r = '0;
        for (int c = 0; c < 10000; c++) begin
            if ($urandom_range(0, 2) == 0) r = W'($urandom);
            step(r, ($urandom_range(0, 3) == 0));
        end

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rr_arbiter.md
RR_ARBITER -- requirements
Module: rr_arbiter

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default 4: number of requesters, legal range 2..32.
REQ-002 SHALL have parameter MODE, default 0: 0 = round-robin, 1 = fixed priority (lowest index wins).
REQ-003 SHALL have parameter IDX_WIDTH, default $clog2(WORD_WIDTH): width of grant_idx.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 reqs  input  WORD_WIDTH  per-requester request, level-sensitive.
REQ-007 done  input  1  holder finished; releases the current grant.
REQ-008 grants  output  WORD_WIDTH  registered one-hot grant, or all-zero.
REQ-009 grant_valid  output  1  registered; high exactly when grants is nonzero.
REQ-010 grant_idx  output  IDX_WIDTH  registered binary index of the granted bit; 0 when grant_valid is low.

Function
REQ-011 SHALL implement two states, IDLE (no grant held) and BUSY (one grant held).
REQ-012 In IDLE with reqs nonzero, SHALL select a winner, then at the next edge load grants/grant_idx, set grant_valid and go to BUSY; one-cycle request-to-grant latency.
REQ-013 In IDLE with reqs all-zero, outputs SHALL stay zero and state SHALL stay IDLE.
REQ-014 Round-robin selection SHALL use pointer register last (one-hot, last granted bit): mask = bits strictly above last; winner = lowest set bit of (reqs & mask) if nonzero, else lowest set bit of reqs (wrap-around).
REQ-015 Fixed-priority selection (MODE=1) SHALL give winner = reqs & -reqs (two's complement, WORD_WIDTH bits); the pointer is ignored.
REQ-016 On every grant load, last SHALL be updated to the new one-hot grant.
REQ-017 In BUSY, the grant SHALL be held unchanged while done is low and reqs[grant_idx] is high, regardless of other requests.
REQ-018 In BUSY, the grant SHALL be released at the edge where done is high or reqs[grant_idx] is low (abort); both high/low together count as one release.
REQ-019 On release with another request pending (reqs excluding the holder nonzero), SHALL re-arbitrate in the same cycle with the holder excluded and load the new grant at the same edge (back-to-back, no bubble), staying in BUSY.
REQ-020 On release with no other request pending, SHALL clear grants, grant_valid and grant_idx at that edge and go to IDLE; the released holder may be re-granted no earlier than one cycle later.
REQ-021 done asserted in IDLE SHALL be ignored.
REQ-022 grants SHALL never have more than one bit set in any cycle.
REQ-023 Round-robin SHALL guarantee that a continuously requesting input is granted within WORD_WIDTH-1 grants of other inputs.

Reset
REQ-024 While rst is high: grants = 0, grant_valid = 0, grant_idx = 0, state = IDLE, last = one-hot MSB (1 << (WORD_WIDTH-1)), so bit 0 has top priority after reset.
REQ-025 Reset asserted mid-grant SHALL drop the grant immediately (asynchronously) with no completion signalled; first grant after deassert follows REQ-012 with the reset pointer.

Verification
REQ-026 WORD_WIDTH=4, MODE=0, reset, reqs=4'b1111 held, done pulsed every cycle -> grants 0001, 0010, 0100, 1000, 0001 on consecutive cycles after the first-grant latency.
REQ-027 MODE=0, reqs=4'b1010 held, done low for 5 cycles -> grants=0010 for all 5 cycles; done high once -> next edge grants=1000, grant_idx=3.
REQ-028 MODE=1, reqs=4'b1110, done each cycle -> grants cycles 0010 then 0100 (holder excluded), then 0010 again; bit 3 granted only when bits 1,2 drop.
REQ-029 Grant held on bit 2, reqs[2] drops with done low, reqs=4'b0000 -> next edge grants=0, grant_valid=0, state IDLE.
REQ-030 Grant held on bit 1, rst pulsed mid-cycle -> grants=0 without waiting for clk; after release with reqs=4'b0110 -> first grant 0010.
REQ-031 Random reqs/done, 10k cycles, WORD_WIDTH=5 -> assertions: grants one-hot-or-zero, grant_valid == |grants, grant_idx matches grants, no starvation beyond 4 foreign grants.
